// File: rtl/spi_pipeline_debug_port_pkg.sv
// Shared definitions for the SPI pipeline debug port: request field positions, op codes,
// FSM state encodings and the error response word.
package spi_pipeline_debug_port_pkg;

  localparam int unsigned OP_MSB = 17;
  localparam int unsigned OP_LSB = 16;
  localparam int unsigned CH_MSB = 15;
  localparam int unsigned CH_LSB = 8;
  localparam int unsigned W_MSB  = 7;
  localparam int unsigned W_LSB  = 0;

  localparam int unsigned CH_W  = CH_MSB - CH_LSB + 1;
  localparam int unsigned W_W   = W_MSB - W_LSB + 1;
  localparam int unsigned REQ_W = OP_MSB - W_LSB + 1;

  localparam int unsigned         ERR_W    = 32;
  localparam logic [ERR_W-1:0]    ERR_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_READ      = 2'b00,
    OP_SNAP      = 2'b01,
    OP_RELEASE   = 2'b10,
    OP_READ_NEXT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_FETCH  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef struct packed {
    op_e             op;
    logic [CH_W-1:0] ch;
    logic [W_W-1:0]  word;
  } req_t;

  function automatic req_t unpack_req(input logic [REQ_W-1:0] d);
    req_t r;
    r.op   = op_e'(d[OP_MSB:OP_LSB]);
    r.ch   = d[CH_MSB:CH_LSB];
    r.word = d[W_MSB:W_LSB];
    return r;
  endfunction

endpackage

// File: rtl/spi_dbg_word_sel.sv
// Combinational (channel, word) selector over the concatenated latch bus; the last word of
// each channel is zero-padded above NB_LATCH-1. Out-of-range selects return zero.
module spi_dbg_word_sel
  import spi_pipeline_debug_port_pkg::*;
#(
  parameter int unsigned NB_BITS  = 32,
  parameter int unsigned NB_LATCH = 96,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned N_WORDS  = 3
) (
  input  logic [N_CH*NB_LATCH-1:0] latch,
  input  logic [CH_W-1:0]          ch,
  input  logic [W_W-1:0]           word,
  output logic [NB_BITS-1:0]       data_c
);

  localparam int unsigned PAD_W = N_WORDS * NB_BITS;

  logic [PAD_W-1:0] padded [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_pad
    assign padded[k] = PAD_W'(latch[k*NB_LATCH +: NB_LATCH]);
  end

  always_comb begin
    data_c = '0;
    for (int k = 0; k < N_CH; k++) begin
      for (int w = 0; w < N_WORDS; w++) begin
        if (ch == CH_W'(k) && word == W_W'(w)) data_c = padded[k][w*NB_BITS +: NB_BITS];
      end
    end
  end

endmodule

// File: rtl/spi_pipeline_debug_port.sv
// SPI debug read port over the pipeline latches with freezeable snapshot.
// Optional auto-increment pointer / READ_NEXT op enabled by SPI_DBG_AUTOINC_EN.
module spi_pipeline_debug_port
  import spi_pipeline_debug_port_pkg::*;
#(
  parameter int unsigned NB_BITS  = 32,
  parameter int unsigned NB_LATCH = 96,
  parameter int unsigned N_CH     = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_CH*NB_LATCH-1:0] i_latch,
  input  logic [NB_BITS-1:0]       i_spi_data,
  input  logic                     i_spi_valid,
  output logic [NB_BITS-1:0]       o_spi_data,
  output logic                     o_spi_valid,
  output logic                     o_busy,
  output logic                     o_frozen,
  output logic                     o_err
);

  localparam int unsigned N_WORDS  = (NB_LATCH + NB_BITS - 1) / NB_BITS;
  localparam int unsigned ERR_REP  = (NB_BITS + ERR_W - 1) / ERR_W;
  localparam logic [NB_BITS-1:0] ERR_RESP = NB_BITS'({ERR_REP{ERR_WORD}});

  state_e state_q, state_d;
  req_t   req_q;

  op_e             dec_op;
  logic [CH_W-1:0] dec_ch;
  logic [W_W-1:0]  dec_w;
  logic            dec_err;

  logic [CH_W-1:0] eff_ch;
  logic [W_W-1:0]  eff_w;
  logic            op_ok;

  logic [N_CH*NB_LATCH-1:0] snap_q;
  logic [NB_BITS-1:0]       live_word, snap_word;

  logic unused_req_hi;
  assign unused_req_hi = ^i_spi_data[NB_BITS-1:REQ_W];

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      o_busy  <= 1'b0;
    end else begin
      state_q <= state_d;
      o_busy  <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_spi_valid) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

`ifdef SPI_DBG_AUTOINC_EN
  logic [CH_W-1:0] ptr_ch_q, ptr_ch_d;
  logic [W_W-1:0]  ptr_w_q, ptr_w_d;

  // Successor of the fetched address: word-major, wrapping after the last channel
  always_comb begin
    ptr_ch_d = dec_ch;
    ptr_w_d  = dec_w + W_W'(1);
    if (dec_w == W_W'(N_WORDS - 1)) begin
      ptr_w_d  = '0;
      ptr_ch_d = (dec_ch == CH_W'(N_CH - 1)) ? '0 : dec_ch + CH_W'(1);
    end
  end
`endif

  always_comb begin
    eff_ch = req_q.ch;
    eff_w  = req_q.word;
    op_ok  = 1'b1;
`ifdef SPI_DBG_AUTOINC_EN
    if (req_q.op == OP_READ_NEXT) begin
      eff_ch = ptr_ch_q;
      eff_w  = ptr_w_q;
    end
`else
    op_ok = (req_q.op != OP_READ_NEXT);
`endif
  end

  spi_dbg_word_sel #(
    .NB_BITS (NB_BITS),
    .NB_LATCH(NB_LATCH),
    .N_CH    (N_CH),
    .N_WORDS (N_WORDS)
  ) u_live_sel (
    .latch (i_latch),
    .ch    (dec_ch),
    .word  (dec_w),
    .data_c(live_word)
  );

  spi_dbg_word_sel #(
    .NB_BITS (NB_BITS),
    .NB_LATCH(NB_LATCH),
    .N_CH    (N_CH),
    .N_WORDS (N_WORDS)
  ) u_snap_sel (
    .latch (snap_q),
    .ch    (dec_ch),
    .word  (dec_w),
    .data_c(snap_word)
  );

  // Request capture, decode stage and fetch/response datapath
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_q       <= '0;
      dec_op      <= OP_READ;
      dec_ch      <= '0;
      dec_w       <= '0;
      dec_err     <= 1'b0;
      snap_q      <= '0;
      o_spi_data  <= '0;
      o_spi_valid <= 1'b0;
      o_frozen    <= 1'b0;
      o_err       <= 1'b0;
`ifdef SPI_DBG_AUTOINC_EN
      ptr_ch_q    <= '0;
      ptr_w_q     <= '0;
`endif
    end else begin
      o_spi_valid <= 1'b0;
      o_err       <= 1'b0;
      if (state_q == ST_IDLE && i_spi_valid) req_q <= unpack_req(i_spi_data[REQ_W-1:0]);
      if (state_q == ST_DECODE) begin
        dec_op  <= req_q.op;
        dec_ch  <= eff_ch;
        dec_w   <= eff_w;
        dec_err <= !op_ok || (eff_ch >= CH_W'(N_CH)) || (eff_w >= W_W'(N_WORDS));
      end
      if (state_q == ST_FETCH) begin
        o_spi_valid <= 1'b1;
        if (dec_err) begin
          o_spi_data <= ERR_RESP;
          o_err      <= 1'b1;
        end else begin
          case (dec_op)
            OP_SNAP: begin
              snap_q     <= i_latch;
              o_frozen   <= 1'b1;
              o_spi_data <= '0;
`ifdef SPI_DBG_AUTOINC_EN
              ptr_ch_q   <= '0;
              ptr_w_q    <= '0;
`endif
            end
            OP_RELEASE: begin
              o_frozen   <= 1'b0;
              o_spi_data <= '0;
            end
            default: begin
              o_spi_data <= o_frozen ? snap_word : live_word;
`ifdef SPI_DBG_AUTOINC_EN
              ptr_ch_q   <= ptr_ch_d;
              ptr_w_q    <= ptr_w_d;
`endif
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_pipeline_debug_port.sv
// Directed self-checking bench for spi_pipeline_debug_port (default parameters).
module tb_spi_pipeline_debug_port;

  localparam int unsigned NB_BITS  = 32;
  localparam int unsigned NB_LATCH = 96;
  localparam int unsigned N_CH     = 4;

  logic                     i_clk = 1'b0;
  logic                     i_rst = 1'b1;
  logic [N_CH*NB_LATCH-1:0] i_latch = '0;
  logic [NB_BITS-1:0]       i_spi_data = '0;
  logic                     i_spi_valid = 1'b0;
  logic [NB_BITS-1:0]       o_spi_data;
  logic                     o_spi_valid;
  logic                     o_busy;
  logic                     o_frozen;
  logic                     o_err;

  int checks = 0;
  int errors = 0;

  spi_pipeline_debug_port #(
    .NB_BITS (NB_BITS),
    .NB_LATCH(NB_LATCH),
    .N_CH    (N_CH)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_latch    (i_latch),
    .i_spi_data (i_spi_data),
    .i_spi_valid(i_spi_valid),
    .o_spi_data (o_spi_data),
    .o_spi_valid(o_spi_valid),
    .o_busy     (o_busy),
    .o_frozen   (o_frozen),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] req_word(input logic [1:0] op, input int ch, input int w);
    return {14'h0, op, 8'(ch), 8'(w)};
  endfunction

  task automatic set_word(input int k, input int w, input logic [31:0] v);
    i_latch[k*NB_LATCH + w*NB_BITS +: NB_BITS] = v;
  endtask

  // Issue one request and wait (bounded) for its response; lat = posedges from request to valid
  task automatic do_req(input logic [1:0] op, input int ch, input int w,
                        output logic [31:0] data, output logic err, output int lat);
    @(negedge i_clk);
    i_spi_data  = req_word(op, ch, w);
    i_spi_valid = 1'b1;
    @(posedge i_clk);
    lat = 1;
    @(negedge i_clk);
    i_spi_valid = 1'b0;
    while (!o_spi_valid && lat < 10) begin
      @(posedge i_clk);
      lat++;
      @(negedge i_clk);
    end
    if (!o_spi_valid) lat = 99;
    data = o_spi_data;
    err  = o_err;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if ({o_spi_data, o_spi_valid, o_busy, o_frozen, o_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b busy=%b frz=%b err=%b required all 0",
               o_spi_data, o_spi_valid, o_busy, o_frozen, o_err);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_read();
    logic [31:0] d; logic e; int lat;
    do_req(2'b00, 1, 0, d, e, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL read_latency: got %0d required 3", lat); end
    checks++;
    if (d !== 32'hCAFE_0001) begin errors++; $display("FAIL read_data: got %h required CAFE0001", d); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL read_err: got %b required 0", e); end
    @(negedge i_clk);
    checks++;
    if (o_spi_valid !== 1'b0 || o_spi_data !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL read_valid_pulse: got v=%b data=%h required v=0 data=CAFE0001", o_spi_valid, o_spi_data);
    end
    do_req(2'b00, 3, 1, d, e, lat);
    checks++;
    if (d !== 32'hA000_0301) begin errors++; $display("FAIL read_c3w1: got %h required A0000301", d); end
  endtask

  task automatic test_snapshot();
    logic [31:0] d; logic e; int lat;
    set_word(2, 2, 32'h1111_2222);
    do_req(2'b01, 0, 0, d, e, lat);
    checks++;
    if (lat !== 3 || d !== 32'h0 || o_frozen !== 1'b1) begin
      errors++;
      $display("FAIL snap_resp: got lat=%0d data=%h frz=%b required 3/0/1", lat, d, o_frozen);
    end
    set_word(2, 2, 32'h3333_4444);
    do_req(2'b00, 2, 2, d, e, lat);
    checks++;
    if (d !== 32'h1111_2222 || o_frozen !== 1'b1) begin
      errors++;
      $display("FAIL snap_read: got %h frz=%b required 11112222 frz=1", d, o_frozen);
    end
    do_req(2'b10, 0, 0, d, e, lat);
    checks++;
    if (d !== 32'h0 || o_frozen !== 1'b0 || e !== 1'b0) begin
      errors++;
      $display("FAIL release_resp: got data=%h frz=%b err=%b required 0/0/0", d, o_frozen, e);
    end
    do_req(2'b00, 2, 2, d, e, lat);
    checks++;
    if (d !== 32'h3333_4444) begin errors++; $display("FAIL release_read: got %h required 33334444", d); end
    do_req(2'b10, 0, 0, d, e, lat);
    checks++;
    if (d !== 32'h0 || o_frozen !== 1'b0 || e !== 1'b0) begin
      errors++;
      $display("FAIL release_noop: got data=%h frz=%b err=%b required 0/0/0", d, o_frozen, e);
    end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int lat;
    do_req(2'b01, 0, 0, d, e, lat);
    set_word(2, 2, 32'h7777_8888);
    do_req(2'b00, 4, 0, d, e, lat);
    checks++;
    if (d !== 32'hFFFF_FFFF || e !== 1'b1 || o_frozen !== 1'b1 || lat !== 3) begin
      errors++;
      $display("FAIL err_channel: got data=%h err=%b frz=%b lat=%0d required FFFFFFFF/1/1/3", d, e, o_frozen, lat);
    end
    @(negedge i_clk);
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b required 0", o_err); end
    do_req(2'b00, 0, 3, d, e, lat);
    checks++;
    if (d !== 32'hFFFF_FFFF || e !== 1'b1 || o_frozen !== 1'b1) begin
      errors++;
      $display("FAIL err_word: got data=%h err=%b frz=%b required FFFFFFFF/1/1", d, e, o_frozen);
    end
    do_req(2'b00, 2, 2, d, e, lat);
    checks++;
    if (d !== 32'h3333_4444 || e !== 1'b0) begin
      errors++;
      $display("FAIL err_snap_kept: got %h err=%b required 33334444/0", d, e);
    end
    do_req(2'b10, 0, 0, d, e, lat);
  endtask

  task automatic test_back_to_back();
    int nresp = 0;
    logic [31:0] first = '0;
    @(negedge i_clk);
    i_spi_data  = req_word(2'b00, 1, 0);
    i_spi_valid = 1'b1;
    @(negedge i_clk);
    i_spi_data  = req_word(2'b00, 2, 2);
    i_spi_valid = 1'b1;
    @(negedge i_clk);
    i_spi_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (o_spi_valid) begin
        nresp++;
        first = o_spi_data;
      end
      @(negedge i_clk);
    end
    checks++;
    if (nresp !== 1) begin errors++; $display("FAIL b2b_count: got %0d responses required 1", nresp); end
    checks++;
    if (first !== 32'hCAFE_0001) begin errors++; $display("FAIL b2b_data: got %h required CAFE0001", first); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int lat;
    do_req(2'b01, 0, 0, d, e, lat);
    set_word(2, 2, 32'h5555_6666);
    do_req(2'b00, 2, 2, d, e, lat);
    @(negedge i_clk);
    i_spi_data  = req_word(2'b00, 2, 2);
    i_spi_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_spi_valid = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b1 || o_frozen !== 1'b1 || o_spi_data !== 32'h7777_8888) begin
      errors++;
      $display("FAIL pre_reset: got busy=%b frz=%b data=%h required 1/1/77778888", o_busy, o_frozen, o_spi_data);
    end
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_spi_data, o_spi_valid, o_busy, o_frozen, o_err} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got data=%h v=%b busy=%b frz=%b err=%b required all 0",
               o_spi_data, o_spi_valid, o_busy, o_frozen, o_err);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    do_req(2'b00, 2, 2, d, e, lat);
    checks++;
    if (d !== 32'h5555_6666 || o_frozen !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL post_reset_read: got %h frz=%b lat=%0d required 55556666/0/3", d, o_frozen, lat);
    end
  endtask

  task automatic test_autoinc();
    logic [31:0] d; logic e; int lat;
`ifdef SPI_DBG_AUTOINC_EN
    do_req(2'b00, 0, 2, d, e, lat);
    checks++;
    if (d !== 32'hA000_0002) begin errors++; $display("FAIL ai_read: got %h required A0000002", d); end
    do_req(2'b11, 0, 0, d, e, lat);
    checks++;
    if (d !== 32'hCAFE_0001 || e !== 1'b0) begin errors++; $display("FAIL ai_next1: got %h required CAFE0001", d); end
    do_req(2'b11, 0, 0, d, e, lat);
    checks++;
    if (d !== 32'hA000_0101) begin errors++; $display("FAIL ai_next2: got %h required A0000101", d); end
    do_req(2'b00, 3, 2, d, e, lat);
    do_req(2'b11, 0, 0, d, e, lat);
    checks++;
    if (d !== 32'hA000_0000) begin errors++; $display("FAIL ai_wrap: got %h required A0000000", d); end
`else
    do_req(2'b11, 0, 0, d, e, lat);
    checks++;
    if (d !== 32'hFFFF_FFFF || e !== 1'b1 || lat !== 3) begin
      errors++;
      $display("FAIL op11_err: got data=%h err=%b lat=%0d required FFFFFFFF/1/3", d, e, lat);
    end
`endif
  endtask

  initial begin
    for (int k = 0; k < int'(N_CH); k++)
      for (int w = 0; w < 3; w++)
        set_word(k, w, 32'hA000_0000 + 32'(k * 256 + w));
    set_word(1, 0, 32'hCAFE_0001);
    test_reset();
    test_read();
    test_snapshot();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_autoinc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
